// File: rtl/dm_pkg.sv
// Shared types for the data memory controller: access sizes, FSM states and
// byte-lane geometry.
package dm_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the data memory: store strobes and
// replicated write data, load lane extraction with sign/zero extension, and
// alignment checking.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]              size_i,
    input  logic [1:0]              addr_lo_i,
    input  logic                    sign_ext_i,
    input  logic [LANES*LANE_W-1:0] wdata_i,
    input  logic [LANES*LANE_W-1:0] rword_i,
    output logic [LANES-1:0]        strb_o,
    output logic [LANES*LANE_W-1:0] wdata_o,
    output logic [LANES*LANE_W-1:0] rdata_o,
    output logic                    misalign_o
);

    size_e       sz;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign sz = size_e'(size_i);

    // Alignment: halves need an even address, words a 4-byte boundary.
    always_comb begin
        misalign_o = 1'b0;
        unique case (sz)
            SZ_BYTE: misalign_o = 1'b0;
            SZ_HALF: misalign_o = addr_lo_i[0];
            SZ_WORD: misalign_o = |addr_lo_i;
            default: misalign_o = 1'b1;
        endcase
    end

    // Store lanes and right-justified data replicated across the word.
    always_comb begin
        strb_o  = 4'b0000;
        wdata_o = wdata_i;
        unique case (sz)
            SZ_BYTE: begin
                strb_o  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                strb_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: strb_o = 4'b1111;
            default: strb_o = 4'b0000;
        endcase
    end

    // Pick the addressed lane(s) out of the stored word.
    always_comb begin
        byte_sel = rword_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = rword_i[7:0];
            2'd1: byte_sel = rword_i[15:8];
            2'd2: byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Right-justify and extend; word loads pass straight through.
    always_comb begin
        rdata_o = rword_i;
        unique case (sz)
            SZ_BYTE: rdata_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
            SZ_WORD: rdata_o = rword_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory for the MIPS datapath: byte/half/word stores with lane strobes,
// registered sub-word loads, misalignment reporting and an optional zero-fill
// sweep after reset.
module dmem_ctrl
    import dm_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = $clog2(DEPTH) + 2,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              ready_q;
    logic              rvalid_q;
    logic              misalign_q;
    logic [DATA_W-1:0] rdata_q;

    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic [LANES-1:0]  strb;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] ld_data;
    logic              mis;

    logic              wr_en_d;
    logic [IDX_W-1:0]  wr_idx_d;
    logic [LANES-1:0]  wr_strb_d;
    logic [DATA_W-1:0] wr_data_d;

    // ready_q is only ever set in ST_RUN, so it alone qualifies requests.
    assign accept   = req_i & ready_q;
    assign word_idx = addr_i[ADDR_W-1:2];

    dm_lane_align u_align (
        .size_i     (size_i),
        .addr_lo_i  (addr_i[1:0]),
        .sign_ext_i (sign_ext_i),
        .wdata_i    (wdata_i),
        .rword_i    (mem_q[word_idx]),
        .strb_o     (strb),
        .wdata_o    (wdata_rep),
        .rdata_o    (ld_data),
        .misalign_o (mis)
    );

    // Write port arbitration: the fill sweep owns the array until ST_RUN.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = '0;
        wr_strb_d = '0;
        wr_data_d = '0;
        if (state_q == ST_INIT) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = cnt_q;
            wr_strb_d = '1;
        end else if (accept && we_i && !mis) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = word_idx;
            wr_strb_d = strb;
            wr_data_d = wdata_rep;
        end
    end

    // Storage array with per-lane write enables; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_d) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_strb_d[l]) begin
                    mem_q[wr_idx_d][LANE_W*l +: LANE_W] <= wr_data_d[LANE_W*l +: LANE_W];
                end
            end
        end
    end

    // Fill FSM plus registered response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        misalign_q <= mis;
                        if (!we_i) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= mis ? '0 : ld_data;
                        end
                    end
                end
            endcase
        end
    end

    assign ready_o    = ready_q;
    assign rvalid_o   = rvalid_q;
    assign rdata_o    = rdata_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (DEPTH=128, INIT_CLEAR=1).
module tb_dmem_ctrl;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [1:0]        size = 2'd0;
    logic              sign_ext = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic              ready;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              misalign;

    int n_total = 0;
    int n_pass  = 0;

    dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .INIT_CLEAR(1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .we_i       (we),
        .size_i     (size),
        .sign_ext_i (sign_ext),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .ready_o    (ready),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .misalign_o (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one request from a negedge; returns on the next negedge, when the
    // registered response of that request is visible.
    task automatic acc(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Count rising edges from reset release until ready rises (bounded).
    task automatic wait_ready(input string tag, input int exp_n);
        int n = 0;
        while (!ready && n < 400) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(tag, n, exp_n);
        @(negedge clk);
    endtask

    initial begin
        int rv_cnt;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        // Zero fill: 128 edges with ready low
        rst_n = 1'b1;
        wait_ready("fill_len", 128);
        acc(1'b0, 2'd2, 1'b0, 9'h000, 32'h0);
        chk("fill_w0", rdata, 32'h0);
        chk("fill_w0_rv", {31'd0, rvalid}, 32'd1);
        acc(1'b0, 2'd2, 1'b0, 9'h1FC, 32'h0);
        chk("fill_w127", rdata, 32'h0);
        acc(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        chk("fill_w4", rdata, 32'h0);

        // Word store then load in consecutive cycles
        acc(1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF);
        chk("sw_rvalid", {31'd0, rvalid}, 32'd0);
        chk("sw_rdata_hold", rdata, 32'h0);
        acc(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        chk("lw_rvalid", {31'd0, rvalid}, 32'd1);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
        chk("rdata_hold", rdata, 32'hDEADBEEF);

        // Byte store into a cleared word; upper wdata bits must be ignored
        acc(1'b1, 2'd2, 1'b0, 9'h010, 32'h0);
        acc(1'b1, 2'd0, 1'b0, 9'h013, 32'hABCDEF80);
        acc(1'b0, 2'd0, 1'b1, 9'h013, 32'h0);
        chk("lb", rdata, 32'hFFFFFF80);
        acc(1'b0, 2'd0, 1'b0, 9'h013, 32'h0);
        chk("lbu", rdata, 32'h00000080);
        acc(1'b0, 2'd2, 1'b0, 9'h010, 32'h0);
        chk("lw_after_sb", rdata, 32'h80000000);
        acc(1'b0, 2'd0, 1'b1, 9'h012, 32'h0);
        chk("lb_zero_lane", rdata, 32'h00000000);

        // Half accesses and misalignment
        acc(1'b1, 2'd1, 1'b0, 9'h022, 32'h55551234);
        chk("sh_misalign", {31'd0, misalign}, 32'd0);
        acc(1'b0, 2'd2, 1'b0, 9'h020, 32'h0);
        chk("lw_after_sh", rdata, 32'h12340000);
        acc(1'b0, 2'd1, 1'b1, 9'h021, 32'h0);
        chk("lh_mis_flag", {31'd0, misalign}, 32'd1);
        chk("lh_mis_rvalid", {31'd0, rvalid}, 32'd1);
        chk("lh_mis_rdata", rdata, 32'h0);
        acc(1'b1, 2'd1, 1'b0, 9'h021, 32'h0000FFFF);
        chk("sh_mis_flag", {31'd0, misalign}, 32'd1);
        chk("sh_mis_rvalid", {31'd0, rvalid}, 32'd0);
        acc(1'b1, 2'd2, 1'b0, 9'h022, 32'hFFFFFFFF);
        chk("sw_mis_flag", {31'd0, misalign}, 32'd1);
        acc(1'b0, 2'd2, 1'b0, 9'h020, 32'h0);
        chk("w20_unchanged", rdata, 32'h12340000);
        chk("w20_misalign", {31'd0, misalign}, 32'd0);
        acc(1'b0, 2'd3, 1'b0, 9'h020, 32'h0);
        chk("ill_ld_flag", {31'd0, misalign}, 32'd1);
        chk("ill_ld_rvalid", {31'd0, rvalid}, 32'd1);
        chk("ill_ld_rdata", rdata, 32'h0);
        acc(1'b1, 2'd3, 1'b0, 9'h020, 32'hFFFFFFFF);
        chk("ill_st_flag", {31'd0, misalign}, 32'd1);
        @(negedge clk);
        chk("mis_pulse", {31'd0, misalign}, 32'd0);
        acc(1'b1, 2'd1, 1'b0, 9'h020, 32'h00008001);
        acc(1'b0, 2'd1, 1'b1, 9'h020, 32'h0);
        chk("lh_sext", rdata, 32'hFFFF8001);
        acc(1'b0, 2'd1, 1'b0, 9'h020, 32'h0);
        chk("lhu", rdata, 32'h00008001);
        acc(1'b0, 2'd1, 1'b1, 9'h022, 32'h0);
        chk("lh_hi", rdata, 32'h00001234);

        // Reset at fill cycle 50 restarts the sweep
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        chk("midfill_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("refill_len", 128);

        // Reset right after a load is accepted drops its rvalid
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 9'h010;
        @(posedge clk);
        #1;
        chk("ld_before_rst", {31'd0, rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_rvalid", {31'd0, rvalid}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        chk("rst_rvalid_low", {31'd0, rvalid}, 32'd0);
        rst_n = 1'b1;
        wait_ready("refill2_len", 128);

        // Sweep: 128 word stores then 128 word loads, one per cycle
        for (int i = 0; i < DEPTH; i++) acc(1'b1, 2'd2, 1'b0, ADDR_W'(4 * i), 32'(10 * i));
        rv_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            acc(1'b0, 2'd2, 1'b0, ADDR_W'(4 * i), 32'h0);
            if (rvalid) rv_cnt++;
            chk($sformatf("sweep_%0d", i), rdata, 32'(10 * i));
        end
        chk("sweep_rvalid_cnt", rv_cnt, 32'd128);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
